// File: rtl/fanout_leaf_checker.sv
// rtl/fanout_leaf_checker.sv - loopback checker driving an alternating pattern into a fanout tree and scoring leaves
module fanout_leaf_checker #(
    parameter int N_LEAF = 20,
    parameter int GROUP  = 5,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8,
    localparam int N_GRP = N_LEAF / GROUP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        num_vec,
    input  logic [N_LEAF-1:0] leaf,
    output logic              drive,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [N_LEAF-1:0] fail_mask,
    output logic [N_GRP-1:0]  group_fail
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         num_q, num_d;
    logic [7:0]         k_q, k_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [N_LEAF-1:0]  mask_q, mask_d;
    logic               pass_q, pass_d;
    logic [N_LEAF-1:0]  mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            mask_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        mask_d  = mask_q;
        pass_d  = pass_q;
        busy    = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
        done    = (state_q == S_DONE);
        // Expected leaf value equals the root drive: the two inversions cancel.
        drive   = busy & ~k_q[0];
        mis     = leaf ^ {N_LEAF{drive}};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d   = num_vec;
                    k_d     = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    mask_d  = '0;
                    pass_d  = 1'b0;
                    state_d = (num_vec == 8'd0) ? S_DONE : S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (cnt_q == SW'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end
            S_SAMPLE: begin
                mask_d = mask_q | mis;
                if ((|mis) && (err_q != {CNT_W{1'b1}})) begin
                    err_d = err_q + CNT_W'(1);
                end
                k_d     = k_q + 8'd1;
                state_d = (({1'b0, k_q} + 9'd1) < {1'b0, num_q}) ? S_DRIVE : S_DONE;
            end
            S_DONE: begin
                pass_d  = (err_q == '0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        group_fail = '0;
        for (int g = 0; g < N_GRP; g++) begin
            group_fail[g] = |mask_q[g*GROUP +: GROUP];
        end
    end

    assign pass      = pass_q;
    assign err_cnt   = err_q;
    assign fail_mask = mask_q;

endmodule

// File: tb/tb_fanout_leaf_checker.sv
// tb/tb_fanout_leaf_checker.sv - directed and randomized runs against a vector-level model of the checker
module tb_fanout_leaf_checker;

    localparam int NL = 20;
    localparam int S1 = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  num_vec;
    logic [NL-1:0] leaf;
    logic [NL-1:0] sa0, sa1, inv;

    logic        drive, busy, done, pass;
    logic [7:0]  err_cnt;
    logic [NL-1:0] fail_mask;
    logic [3:0]  group_fail;

    logic        s_drive, s_busy, s_done, s_pass;
    logic [1:0]  s_err_cnt;
    logic [NL-1:0] s_fail_mask;
    logic [3:0]  s_group_fail;

    int n_vec = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Emulated tree: leaves follow the root unless faulted.
    assign leaf = (({NL{drive}} ^ inv) & ~sa0) | sa1;

    fanout_leaf_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec), .leaf(leaf),
        .drive(drive), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .fail_mask(fail_mask), .group_fail(group_fail)
    );

    fanout_leaf_checker #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec), .leaf(leaf),
        .drive(s_drive), .busy(s_busy), .done(s_done), .pass(s_pass), .err_cnt(s_err_cnt),
        .fail_mask(s_fail_mask), .group_fail(s_group_fail)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NL-1:0] tree_mis(input int j);
        logic [NL-1:0] d;
        d = (j % 2 == 0) ? {NL{1'b1}} : {NL{1'b0}};
        return ((((d ^ inv) & ~sa0) | sa1) ^ d);
    endfunction

    function automatic logic [3:0] grp(input logic [NL-1:0] m);
        logic [3:0] g;
        for (int i = 0; i < 4; i++) g[i] = |m[i*5 +: 5];
        return g;
    endfunction

    task automatic run(input int n, input int pulse);
        logic [NL-1:0] mis[$];
        logic [NL-1:0] acc;
        int raw, comp, dones;
        mis = {};
        for (int j = 0; j < n; j++) mis.push_back(tree_mis(j));
        dones = 0;
        @(negedge clk);
        start = 1'b1;
        num_vec = n[7:0];
        for (int c = 1; c <= n*S1 + 2; c++) begin
            @(negedge clk);
            if (c == 1 || c == pulse + 1) start = 1'b0;
            comp = (c - 1) / S1;
            if (comp > n) comp = n;
            raw = 0;
            acc = '0;
            for (int j = 0; j < comp; j++) begin
                acc |= mis[j];
                if (|mis[j]) raw++;
            end
            if (done) dones++;
            if (c <= n*S1) begin
                chk("drive", drive, (((c - 1) / S1) % 2 == 0));
                chk("busy", busy, 1);
                chk("done_low", done, 0);
            end else if (c == n*S1 + 1) begin
                chk("done_drive", drive, 0);
                chk("done_busy", busy, 0);
                chk("done", done, 1);
            end else begin
                chk("idle_done", done, 0);
                chk("pass", pass, (raw == 0));
                chk("sat_pass", s_pass, (raw == 0));
                chk("done_count", dones, 1);
            end
            chk("err_cnt", err_cnt, (raw > 255) ? 255 : raw);
            chk("sat_err_cnt", s_err_cnt, (raw > 3) ? 3 : raw);
            chk("fail_mask", fail_mask, acc);
            chk("group_fail", group_fail, grp(acc));
            if (c == pulse) begin
                start = 1'b1;
                num_vec = 8'd9;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        num_vec = '0;
        sa0 = '0; sa1 = '0; inv = '0;
        repeat (2) @(negedge clk);
        chk("rst_drive", drive, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_mask", fail_mask, 0);
        rst_n = 1'b1;

        // clean tree
        run(4, -10);
        // stuck-at-0 on leaf 7
        sa0 = 20'h00080;
        run(4, -10);
        chk("sa0_mask", fail_mask, 32'h00080);
        chk("sa0_grp", group_fail, 4'b0010);
        chk("sa0_err", err_cnt, 2);
        sa0 = '0;
        // saturation: all leaves inverted
        inv = {NL{1'b1}};
        run(6, -10);
        chk("sat_mask", s_fail_mask, 32'hFFFFF);
        chk("sat_grp", s_group_fail, 4'hF);
        inv = '0;
        // zero vectors
        run(0, -10);
        // start while busy
        run(4, 5);
        // randomized fault patterns
        for (int r = 0; r < 6; r++) begin
            sa0 = NL'($urandom & $urandom & $urandom);
            sa1 = NL'($urandom & $urandom & $urandom);
            inv = NL'($urandom & $urandom & $urandom);
            run($urandom_range(1, 10), (r % 2 == 0) ? $urandom_range(2, 6) : -10);
        end
        sa1 = '0; inv = '0;

        // reset mid-run after leaf 7 was recorded
        sa0 = 20'h00080;
        @(negedge clk);
        start = 1'b1;
        num_vec = 8'd4;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("mid_err", err_cnt, 1);
        chk("mid_mask", fail_mask, 32'h00080);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_drive", drive, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_pass", pass, 0);
        chk("arst_err", err_cnt, 0);
        chk("arst_mask", fail_mask, 0);
        chk("arst_grp", group_fail, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sa0 = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_drive", drive, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
